// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares the fifo1 write port among NREQ valid/ready requesters,
// with bursts of up to BURST beats per grant. Optional per-requester beat counters via FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4
`ifdef FIFO_ARB_STATS_EN
    ,parameter int CNTW = 16
`endif
    ,localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [GW-1:0]         grant_id,
    output logic                  busy
`ifdef FIFO_ARB_STATS_EN
    ,output logic [NREQ*CNTW-1:0] write_cnt
`endif
);

    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_nxt;
    logic [GW-1:0]  rr_ptr, pick, rr_nxt;
    logic [BW-1:0]  beat_cnt;
    logic           g_valid, last_beat, release_g;

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        pick = rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NREQ])
                pick = GW'((int'(rr_ptr) + k) % NREQ);
        end
    end

    assign g_valid   = req_valid[grant_id];
    assign last_beat = (beat_cnt == BW'(BURST - 1));
    assign release_g = (winc & last_beat) | ~g_valid;
    assign rr_nxt    = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + GW'(1);

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_valid) state_nxt = GRANT;
            GRANT:   if (release_g)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        winc      = 1'b0;
        req_ready = '0;
        busy      = 1'b0;
        wdata     = req_data[int'(grant_id)*DSIZE +: DSIZE];
        if (state == GRANT) begin
            busy                = 1'b1;
            req_ready[grant_id] = ~wfull;
            winc                = g_valid & ~wfull;
        end
    end

    // A stalled grant (wfull) holds both grant_id and beat_cnt until the FIFO drains.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant_id <= pick;
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (release_g) begin
                        rr_ptr   <= rr_nxt;
                        beat_cnt <= '0;
                    end else if (winc) begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NREQ-1:0][CNTW-1:0] cnt;

    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        always_ff @(posedge wclk or posedge wrst) begin
            if (wrst)
                cnt[i] <= '0;
            else if (winc && grant_id == GW'(i) && cnt[i] != '1)
                cnt[i] <= cnt[i] + CNTW'(1);
        end
    end

    assign write_cnt = cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: cycle table of inputs/expected outputs plus hand-written
// sequences for async reset mid-burst and (with FIFO_ARB_STATS_EN) the saturating counters.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;
`ifdef FIFO_ARB_STATS_EN
    localparam int CNTW  = 4;
`endif

    logic                  wclk = 1'b0;
    logic                  wrst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*DSIZE-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull = 1'b0;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [1:0]            grant_id;
    logic                  busy;
`ifdef FIFO_ARB_STATS_EN
    logic [NREQ*CNTW-1:0]  write_cnt;
`endif

    fifo_wr_arbiter #(
        .NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)
`ifdef FIFO_ARB_STATS_EN
        ,.CNTW(CNTW)
`endif
    ) dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
        .grant_id(grant_id), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
        ,.write_cnt(write_cnt)
`endif
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic        rst;
        logic [3:0]  rv;
        logic [31:0] d;
        logic        wf;
        logic        e_winc;
        logic [3:0]  e_rdy;
        logic [1:0]  e_gid;
        logic        e_busy;
        logic [7:0]  e_wd;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(input logic r, input logic [3:0] rv, input logic [31:0] d, input logic wf,
                       input logic ew, input logic [3:0] er, input logic [1:0] eg,
                       input logic eb, input logic [7:0] ewd);
        vec_t v;
        v.rst = r; v.rv = rv; v.d = d; v.wf = wf;
        v.e_winc = ew; v.e_rdy = er; v.e_gid = eg; v.e_busy = eb; v.e_wd = ewd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] da(input logic [7:0] x);
        return {8'h00, x, 16'h0000};
    endfunction

    localparam logic [31:0] DD = 32'hD3D2D1D0;

    initial begin
        // reset, then single requester 2 with data A0..A5
        add(1, 4'hF, DD, 0, 0, 4'h0, 0, 0, 8'h00);
        add(0, 4'b0100, da(8'hA0), 0, 0, 4'h0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++)
            add(0, 4'b0100, da(8'(8'hA0 + i)), 0, 1, 4'b0100, 2, 1, 8'(8'hA0 + i));
        add(0, 4'b0100, da(8'hA4), 0, 0, 4'h0, 2, 0, 8'h00);
        add(0, 4'b0100, da(8'hA4), 0, 1, 4'b0100, 2, 1, 8'hA4);
        add(0, 4'b0100, da(8'hA5), 0, 1, 4'b0100, 2, 1, 8'hA5);
        add(0, 4'b0000, da(8'h00), 0, 0, 4'b0100, 2, 1, 8'h00);
        add(0, 4'b0000, da(8'h00), 0, 0, 4'h0, 2, 0, 8'h00);
        // contention, all four requesting
        add(1, 4'hF, DD, 0, 0, 4'h0, 0, 0, 8'h00);
        add(0, 4'hF, DD, 0, 0, 4'h0, 0, 0, 8'h00);
        for (int g = 0; g < 4; g++) begin
            for (int b = 0; b < 4; b++)
                add(0, 4'hF, DD, 0, 1, 4'(1 << g), 2'(g), 1, 8'(8'hD0 + g));
            add(0, 4'hF, DD, 0, 0, 4'h0, 2'(g), 0, 8'h00);
        end
        // backpressure: one beat, 3 stalled cycles, 3 more beats
        add(0, 4'hF, DD, 0, 1, 4'b0001, 0, 1, 8'hD0);
        for (int i = 0; i < 3; i++) add(0, 4'hF, DD, 1, 0, 4'h0, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) add(0, 4'hF, DD, 0, 1, 4'b0001, 0, 1, 8'hD0);
        add(0, 4'hF, DD, 0, 0, 4'h0, 0, 0, 8'h00);
        // early release of requester 1 after 2 beats; next pick starts at 2
        add(0, 4'hF, DD, 0, 1, 4'b0010, 1, 1, 8'hD1);
        add(0, 4'hF, DD, 0, 1, 4'b0010, 1, 1, 8'hD1);
        add(0, 4'b1101, DD, 0, 0, 4'b0010, 1, 1, 8'h00);
        add(0, 4'b1101, DD, 0, 0, 4'h0, 1, 0, 8'h00);
        add(0, 4'b1101, DD, 0, 1, 4'b0100, 2, 1, 8'hD2);

        foreach (vecs[i]) begin
            @(negedge wclk);
            wrst = vecs[i].rst; req_valid = vecs[i].rv; req_data = vecs[i].d; wfull = vecs[i].wf;
            #1;
            n_cmp++;
            if ({winc, req_ready, grant_id, busy} !==
                    {vecs[i].e_winc, vecs[i].e_rdy, vecs[i].e_gid, vecs[i].e_busy} ||
                (vecs[i].e_winc && wdata !== vecs[i].e_wd)) begin
                n_fail++;
                $display("FAIL vec%0d: got winc=%b rdy=%b gid=%0d busy=%b wdata=%h expected winc=%b rdy=%b gid=%0d busy=%b wdata=%h",
                         i, winc, req_ready, grant_id, busy, wdata, vecs[i].e_winc, vecs[i].e_rdy,
                         vecs[i].e_gid, vecs[i].e_busy, vecs[i].e_wd);
            end
        end

        // async reset in the middle of requester 2's burst; rr_ptr must restart at 0
        @(negedge wclk);
        req_valid = 4'hF;
        #1;
        chk("burst_live", {winc, grant_id}, {1'b1, 2'd2});
        wrst = 1'b1;
        #1;
        chk("midburst_rst", {winc, req_ready, busy, grant_id}, '0);
        @(negedge wclk);
        wrst = 1'b0; req_valid = 4'b1010;
        #1;
        chk("post_rst_idle", {winc, busy}, '0);
        @(negedge wclk);
        #1;
        chk("post_rst_pick", {winc, req_ready, grant_id}, {1'b1, 4'b0010, 2'd1});

`ifdef FIFO_ARB_STATS_EN
        begin
            int beats = 0;
            @(negedge wclk); wrst = 1'b1;
            @(negedge wclk); wrst = 1'b0;
            for (int c = 0; c < 80; c++) begin
                @(negedge wclk);
                req_valid = (beats < 20) ? 4'b1000 : 4'b0000;
                #1;
                if (winc) beats++;
            end
            chk("stats_beats", 64'(beats), 64'd20);
            chk("stats_sat3", 64'(write_cnt[3*CNTW +: CNTW]), 64'd15);
            chk("stats_others", 64'(write_cnt[3*CNTW-1:0]), 64'd0);
            @(negedge wclk); req_valid = 4'b1000;
            @(negedge wclk); #1;
            chk("stats_live", {winc, grant_id}, {1'b1, 2'd3});
            wrst = 1'b1;
            #1;
            chk("stats_rst", {write_cnt, winc, busy}, '0);
            @(negedge wclk); wrst = 1'b0; req_valid = '0;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
